// File: rtl/pipeline_skid_register.sv
// pipeline_skid_register
//
// Elastic two-entry pipeline stage (main + skid register) with a valid/ready
// handshake on both sides. All handshake outputs are registered, so there is
// no combinational path from valid_in/ready_in/data_in to any output. The
// skid entry absorbs the one in-flight word that a registered ready_out
// implies. It also keeps saturating hazard counters for stalls and flushes.
//
// Parameters:
//   WIDTH        payload width in bits (>= 1)
//   COUNT_WIDTH  width of each statistics counter (>= 2)
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   flush        synchronous flush, discards all held entries
//   count_clear  synchronous zeroing of both counters
//   valid_in     upstream offers data_in
//   ready_out    stage can accept this cycle (registered)
//   data_in      upstream payload
//   valid_out    data_out holds a valid entry (registered)
//   ready_in     downstream accepts this cycle
//   data_out     head payload (registered, never X)
//   occupancy    number of held entries, 0..2
//   stall_count  cycles with valid_out=1 and ready_in=0, saturating
//   flush_count  cycles with flush=1, saturating
module pipeline_skid_register #(
  parameter int WIDTH       = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   count_clear,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [WIDTH-1:0]       data_in,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [WIDTH-1:0]       data_out,
  output logic [1:0]             occupancy,
  output logic [COUNT_WIDTH-1:0] stall_count,
  output logic [COUNT_WIDTH-1:0] flush_count
);

  // State encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_valid;
  logic                   r_ready;
  logic [WIDTH-1:0]       r_main;
  logic [WIDTH-1:0]       r_skid;
  logic [COUNT_WIDTH-1:0] r_stall_count;
  logic [COUNT_WIDTH-1:0] r_flush_count;

  logic w_accept;
  logic w_emit;
  logic w_stall;

  assign w_accept = valid_in & r_ready;
  assign w_emit   = r_valid & ready_in;
  assign w_stall  = r_valid & ~ready_in;

  // Storage and handshake FSM. valid/ready are kept as their own registers
  // (rather than decoded from r_state) so the outputs come straight from flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      // Flush wins over any transfer; an emit in this cycle is still delivered
      // because the downstream already sampled data_out.
      r_state <= EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_main  <= data_in;
            r_state <= HALF;
            r_valid <= 1'b1;
          end
        end
        HALF: begin
          if (w_accept && w_emit) begin
            r_main <= data_in;
          end else if (w_accept) begin
            // Head is stuck; park the newcomer in the skid and drop ready.
            r_skid  <= data_in;
            r_state <= FULL;
            r_ready <= 1'b0;
          end else if (w_emit) begin
            // r_main keeps the last emitted value while empty.
            r_state <= EMPTY;
            r_valid <= 1'b0;
          end
        end
        FULL: begin
          if (w_emit) begin
            r_main  <= r_skid;
            r_state <= HALF;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Statistics counters: saturate at all-ones, clear has priority, and
  // they are independent of flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else if (count_clear) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall && !(&r_stall_count)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
      if (flush && !(&r_flush_count)) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  assign ready_out   = r_ready;
  assign valid_out   = r_valid;
  assign data_out    = r_main;
  assign occupancy   = r_state;
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

endmodule
